// File: rtl/wishbone_peri_fifo_if.sv
// Wishbone B4 pipelined slave bus bundle for the peripheral FIFO block.
interface wishbone_peri_fifo_if;
  logic       wb_cyc;
  logic       wb_stb;
  logic       wb_we;
  logic [1:0] wb_adr;
  logic [7:0] wb_dat_w;
  logic [7:0] wb_dat_r;
  logic       wb_ack;
  logic       wb_stall;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w,
    input  wb_dat_r, wb_ack, wb_stall
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w,
    output wb_dat_r, wb_ack, wb_stall
  );
endinterface

// File: rtl/wishbone_peri_fifo.sv
// Wishbone peripheral with a TX byte FIFO (bus -> stream) and an RX byte FIFO (stream -> bus).
// Optional interrupt output enabled by defining WISHBONE_PERI_FIFO_IRQ_EN.
module wishbone_peri_fifo #(
  parameter int DEPTH_LOG2 = 3  // legal range 1..3 so counts fit the 4-bit COUNT fields
) (
  input  logic                    clk,
  input  logic                    rst,
  wishbone_peri_fifo_if.slave     wb,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready
`ifdef WISHBONE_PERI_FIFO_IRQ_EN
  ,
  output logic                    irq
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_CTRL   = 2'd2;
  localparam logic [1:0] ADR_COUNT  = 2'd3;

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);

  logic [7:0]            tx_mem [DEPTH];
  logic [7:0]            rx_mem [DEPTH];

  logic [DEPTH_LOG2-1:0] tx_wr_ptr_reg, tx_wr_ptr_next;
  logic [DEPTH_LOG2-1:0] tx_rd_ptr_reg, tx_rd_ptr_next;
  logic [CW-1:0]         tx_count_reg,  tx_count_next;
  logic [DEPTH_LOG2-1:0] rx_wr_ptr_reg, rx_wr_ptr_next;
  logic [DEPTH_LOG2-1:0] rx_rd_ptr_reg, rx_rd_ptr_next;
  logic [CW-1:0]         rx_count_reg,  rx_count_next;
  logic                  ovf_reg, ovf_next;
  logic                  unf_reg, unf_next;
  logic                  ack_reg;
  logic [7:0]            dat_r_reg, dat_r_next;

  logic       req, wr_req, rd_req;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_push_req, tx_push, tx_pop;
  logic       rx_pop_req, rx_pop, rx_push;
  logic       ctrl_wr, flush_tx, flush_rx, clr_flags;
  logic       ovf_set, unf_set;
  logic [DEPTH-1:0] tx_we, rx_we;

  // Request decode: every cycle with cyc&stb is one complete request.
  assign req      = wb.wb_cyc & wb.wb_stb;
  assign wr_req   = req & wb.wb_we;
  assign rd_req   = req & ~wb.wb_we;

  assign tx_full  = (tx_count_reg == CNT_FULL);
  assign tx_empty = (tx_count_reg == '0);
  assign rx_full  = (rx_count_reg == CNT_FULL);
  assign rx_empty = (rx_count_reg == '0);

  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;
  assign tx_data  = tx_valid ? tx_mem[tx_rd_ptr_reg] : 8'h00;

  assign tx_pop      = tx_valid & tx_ready;
  assign tx_push_req = wr_req & (wb.wb_adr == ADR_DATA);
  // A full TX FIFO still takes a byte when the head leaves in the same cycle.
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign ovf_set     = tx_push_req & tx_full & ~tx_pop;

  assign rx_push     = rx_valid & rx_ready;
  assign rx_pop_req  = rd_req & (wb.wb_adr == ADR_DATA);
  assign rx_pop      = rx_pop_req & ~rx_empty;
  assign unf_set     = rx_pop_req & rx_empty;

  assign ctrl_wr     = wr_req & (wb.wb_adr == ADR_CTRL);
  assign flush_tx    = ctrl_wr & wb.wb_dat_w[0];
  assign flush_rx    = ctrl_wr & wb.wb_dat_w[1];
  assign clr_flags   = ctrl_wr & wb.wb_dat_w[2];

  assign wb.wb_stall = 1'b0;
  assign wb.wb_ack   = ack_reg;
  assign wb.wb_dat_r = dat_r_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_we
      assign tx_we[gi] = tx_push & ~flush_tx & (tx_wr_ptr_reg == DEPTH_LOG2'(gi));
      assign rx_we[gi] = rx_push & ~flush_rx & (rx_wr_ptr_reg == DEPTH_LOG2'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (tx_we[i]) tx_mem[i] <= wb.wb_dat_w;
      if (rx_we[i]) rx_mem[i] <= rx_data;
    end
  end

  // Flush wins over any push/pop landing on the same FIFO.
  always_comb begin
    tx_wr_ptr_next = tx_wr_ptr_reg;
    tx_rd_ptr_next = tx_rd_ptr_reg;
    tx_count_next  = tx_count_reg;
    if (flush_tx) begin
      tx_wr_ptr_next = '0;
      tx_rd_ptr_next = '0;
      tx_count_next  = '0;
    end else begin
      if (tx_push) tx_wr_ptr_next = tx_wr_ptr_reg + PTR_ONE;
      if (tx_pop)  tx_rd_ptr_next = tx_rd_ptr_reg + PTR_ONE;
      if (tx_push && !tx_pop)      tx_count_next = tx_count_reg + CNT_ONE;
      else if (!tx_push && tx_pop) tx_count_next = tx_count_reg - CNT_ONE;
    end
  end

  always_comb begin
    rx_wr_ptr_next = rx_wr_ptr_reg;
    rx_rd_ptr_next = rx_rd_ptr_reg;
    rx_count_next  = rx_count_reg;
    if (flush_rx) begin
      rx_wr_ptr_next = '0;
      rx_rd_ptr_next = '0;
      rx_count_next  = '0;
    end else begin
      if (rx_push) rx_wr_ptr_next = rx_wr_ptr_reg + PTR_ONE;
      if (rx_pop)  rx_rd_ptr_next = rx_rd_ptr_reg + PTR_ONE;
      if (rx_push && !rx_pop)      rx_count_next = rx_count_reg + CNT_ONE;
      else if (!rx_push && rx_pop) rx_count_next = rx_count_reg - CNT_ONE;
    end
  end

  always_comb begin
    ovf_next   = (ovf_reg & ~clr_flags) | ovf_set;
    unf_next   = (unf_reg & ~clr_flags) | unf_set;
    dat_r_next = 8'h00;
    if (rd_req) begin
      case (wb.wb_adr)
        ADR_DATA:   dat_r_next = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_reg];
        ADR_STATUS: dat_r_next = {2'b00, unf_reg, ovf_reg, rx_empty, rx_full, tx_empty, tx_full};
        ADR_CTRL:   dat_r_next = 8'h00;
        ADR_COUNT:  dat_r_next = {4'(rx_count_reg), 4'(tx_count_reg)};
        default:    dat_r_next = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      tx_count_reg  <= '0;
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      rx_count_reg  <= '0;
      ovf_reg       <= 1'b0;
      unf_reg       <= 1'b0;
      ack_reg       <= 1'b0;
      dat_r_reg     <= 8'h00;
    end else begin
      tx_wr_ptr_reg <= tx_wr_ptr_next;
      tx_rd_ptr_reg <= tx_rd_ptr_next;
      tx_count_reg  <= tx_count_next;
      rx_wr_ptr_reg <= rx_wr_ptr_next;
      rx_rd_ptr_reg <= rx_rd_ptr_next;
      rx_count_reg  <= rx_count_next;
      ovf_reg       <= ovf_next;
      unf_reg       <= unf_next;
      ack_reg       <= req;
      dat_r_reg     <= dat_r_next;
    end
  end

`ifdef WISHBONE_PERI_FIFO_IRQ_EN
  logic irq_reg;

  // Built from next-state values so irq tracks the flags and RX count without extra lag.
  always_ff @(posedge clk) begin
    if (rst) irq_reg <= 1'b0;
    else     irq_reg <= (rx_count_next != '0) | ovf_next | unf_next;
  end

  assign irq = irq_reg;
`endif

endmodule

// File: tb/tb_wishbone_peri_fifo.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_wishbone_peri_fifo;
  localparam int DEPTH_LOG2 = 3;
  localparam int DEPTH      = 2 ** DEPTH_LOG2;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
`ifdef WISHBONE_PERI_FIFO_IRQ_EN
  logic       irq;
`endif

  wishbone_peri_fifo_if wb_bus ();

  wishbone_peri_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb       (wb_bus.slave),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
`ifdef WISHBONE_PERI_FIFO_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus for the next cycle
  logic       d_rst, d_cyc, d_stb, d_we, d_tx_ready, d_rx_valid;
  logic [1:0] d_adr;
  logic [7:0] d_dat, d_rx_data;

  // Reference model state
  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];
  logic       m_ovf, m_unf;
  logic       exp_ack, exp_rd;
  logic [7:0] exp_dat;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  tx_n, rx_n;
    bit  req, tx_pop, rx_push;
    logic ovf0, unf0;
    if (d_rst) begin
      tx_q.delete(); rx_q.delete();
      m_ovf = 0; m_unf = 0; exp_ack = 0; exp_rd = 0; exp_dat = 8'h00;
      return;
    end
    tx_n = tx_q.size(); rx_n = rx_q.size();
    ovf0 = m_ovf; unf0 = m_unf;
    req     = d_cyc && d_stb;
    tx_pop  = (tx_n != 0) && d_tx_ready;
    rx_push = d_rx_valid && (rx_n < DEPTH);
    exp_ack = req;
    exp_rd  = req && !d_we;
    exp_dat = 8'h00;
    if (tx_pop) void'(tx_q.pop_front());
    if (req && !d_we) begin
      case (d_adr)
        2'd0: if (rx_n == 0) m_unf = 1; else exp_dat = rx_q.pop_front();
        2'd1: exp_dat = {2'b00, unf0, ovf0, rx_n == 0, rx_n == DEPTH, tx_n == 0, tx_n == DEPTH};
        2'd3: exp_dat = {4'(rx_n), 4'(tx_n)};
        default: exp_dat = 8'h00;
      endcase
    end
    if (req && d_we && d_adr == 2'd0) begin
      if (tx_n == DEPTH && !tx_pop) m_ovf = 1;
      else tx_q.push_back(d_dat);
    end
    if (rx_push) rx_q.push_back(d_rx_data);
    if (req && d_we && d_adr == 2'd2) begin
      if (d_dat[0]) tx_q.delete();
      if (d_dat[1]) rx_q.delete();
      if (d_dat[2]) begin m_ovf = 0; m_unf = 0; end
    end
  endtask

  task automatic tick();
    logic       t_req, t_we;
    logic [1:0] t_adr;
    logic [7:0] t_dat;
    rst             = d_rst;
    wb_bus.wb_cyc   = d_cyc;
    wb_bus.wb_stb   = d_stb;
    wb_bus.wb_we    = d_we;
    wb_bus.wb_adr   = d_adr;
    wb_bus.wb_dat_w = d_dat;
    tx_ready        = d_tx_ready;
    rx_valid        = d_rx_valid;
    rx_data         = d_rx_data;
    t_req = d_cyc && d_stb && !d_rst; t_we = d_we; t_adr = d_adr; t_dat = d_dat;
    model_step();
    @(posedge clk); #1;
    check_eq("ack", {31'b0, wb_bus.wb_ack}, {31'b0, exp_ack});
    if (exp_ack && exp_rd) check_eq("dat_r", {24'b0, wb_bus.wb_dat_r}, {24'b0, exp_dat});
    check_eq("tx_valid", {31'b0, tx_valid}, (tx_q.size() != 0) ? 32'd1 : 32'd0);
    check_eq("tx_data", {24'b0, tx_data}, (tx_q.size() != 0) ? {24'b0, tx_q[0]} : 32'd0);
    check_eq("rx_ready", {31'b0, rx_ready}, (rx_q.size() < DEPTH) ? 32'd1 : 32'd0);
    check_eq("stall", {31'b0, wb_bus.wb_stall}, 32'd0);
`ifdef WISHBONE_PERI_FIFO_IRQ_EN
    check_eq("irq", {31'b0, irq}, (rx_q.size() != 0 || m_ovf || m_unf) ? 32'd1 : 32'd0);
`endif
    if (t_req) begin
      if (t_we) $display("wb write adr=%0d dat=%02h", t_adr, t_dat);
      else      $display("wb read  adr=%0d dat=%02h", t_adr, wb_bus.wb_dat_r);
    end
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [7:0] dat);
    d_cyc = 1; d_stb = 1; d_we = 1; d_adr = adr; d_dat = dat;
    tick();
    d_cyc = 0; d_stb = 0; d_we = 0;
  endtask

  task automatic wb_read(input logic [1:0] adr, output logic [7:0] dat);
    d_cyc = 1; d_stb = 1; d_we = 0; d_adr = adr; d_dat = 8'h00;
    tick();
    dat = wb_bus.wb_dat_r;
    d_cyc = 0; d_stb = 0;
  endtask

  initial begin
    logic [7:0] v;
    d_rst = 1; d_cyc = 0; d_stb = 0; d_we = 0; d_adr = 0; d_dat = 0;
    d_tx_ready = 0; d_rx_valid = 0; d_rx_data = 0;
    m_ovf = 0; m_unf = 0; exp_ack = 0; exp_rd = 0; exp_dat = 0;
    repeat (2) tick();
    d_rst = 0;
    check_eq("rst_ack", {31'b0, wb_bus.wb_ack}, 32'd0);
    check_eq("rst_dat_r", {24'b0, wb_bus.wb_dat_r}, 32'd0);
    check_eq("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check_eq("rst_rx_ready", {31'b0, rx_ready}, 32'd1);

    // Two bytes out through the TX stream in order
    wb_write(2'd0, 8'h41);
    wb_write(2'd0, 8'h42);
    check_eq("tx_head_41", {24'b0, tx_data}, 32'h41);
    d_tx_ready = 1;
    tick();
    check_eq("tx_head_42", {24'b0, tx_data}, 32'h42);
    tick();
    check_eq("tx_drained", {31'b0, tx_valid}, 32'd0);
    d_tx_ready = 0;

    // Overflow: nine writes into an eight-deep FIFO
    for (int i = 0; i < 9; i++) wb_write(2'd0, 8'(8'h10 + i));
    wb_read(2'd3, v);
    check_eq("ovf_count", {24'b0, v}, 32'h08);
    wb_read(2'd1, v);
    check_eq("ovf_status_full", {31'b0, v[0]}, 32'd1);
    check_eq("ovf_status_flag", {31'b0, v[4]}, 32'd1);
    d_tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      check_eq("ovf_drain", {24'b0, tx_data}, 32'h10 + i);
      tick();
    end
    check_eq("ovf_no_ninth", {31'b0, tx_valid}, 32'd0);
    d_tx_ready = 0;
    wb_write(2'd2, 8'h04);

    // RX single byte, then underflow on an empty read
    d_rx_valid = 1; d_rx_data = 8'h5A;
    tick();
    d_rx_valid = 0;
    wb_read(2'd0, v);
    check_eq("rx_5a_ack", {31'b0, wb_bus.wb_ack}, 32'd1);
    check_eq("rx_5a_data", {24'b0, v}, 32'h5A);
    wb_read(2'd0, v);
    check_eq("unf_data", {24'b0, v}, 32'h00);
    wb_read(2'd1, v);
    check_eq("unf_flag", {31'b0, v[5]}, 32'd1);
    tick();
    check_eq("ack_idle", {31'b0, wb_bus.wb_ack}, 32'd0);
    wb_write(2'd2, 8'h04);

    // Fill RX, then flush it
    d_rx_valid = 1;
    for (int i = 0; i < 8; i++) begin
      d_rx_data = 8'(8'hC0 + i);
      tick();
    end
    d_rx_valid = 0;
    check_eq("rx_full_ready", {31'b0, rx_ready}, 32'd0);
    wb_write(2'd2, 8'h02);
    check_eq("rx_flush_ready", {31'b0, rx_ready}, 32'd1);
    wb_read(2'd1, v);
    check_eq("rx_flush_empty", {31'b0, v[3]}, 32'd1);

    // Pointer wrap: 20 bytes streamed with reads overlapping pushes
    for (int k = 0; k < 20; k++) begin
      d_rx_valid = 1; d_rx_data = 8'(8'h80 + k);
      if (k >= 2) begin d_cyc = 1; d_stb = 1; d_we = 0; d_adr = 2'd0; end
      tick();
      if (k >= 2) check_eq("wrap_data", {24'b0, wb_bus.wb_dat_r}, 32'h80 + k - 2);
      d_cyc = 0; d_stb = 0;
    end
    d_rx_valid = 0;
    wb_read(2'd3, v);
    check_eq("wrap_count", {24'b0, v}, 32'h20);
    wb_read(2'd0, v);
    check_eq("wrap_tail0", {24'b0, v}, 32'h92);
    wb_read(2'd0, v);
    check_eq("wrap_tail1", {24'b0, v}, 32'h93);

    // Reset arriving with a read request in flight
    d_rx_valid = 1; d_rx_data = 8'h33;
    tick();
    d_rx_valid = 0;
    wb_write(2'd0, 8'h77);
    d_cyc = 1; d_stb = 1; d_we = 0; d_adr = 2'd0; d_rst = 1;
    tick();
    check_eq("rst_mid_ack", {31'b0, wb_bus.wb_ack}, 32'd0);
    check_eq("rst_mid_dat", {24'b0, wb_bus.wb_dat_r}, 32'd0);
    check_eq("rst_mid_txv", {31'b0, tx_valid}, 32'd0);
    check_eq("rst_mid_txd", {24'b0, tx_data}, 32'd0);
    check_eq("rst_mid_rxr", {31'b0, rx_ready}, 32'd1);
    d_rst = 0; d_cyc = 0; d_stb = 0;
    tick();
    check_eq("rst_mid_noack", {31'b0, wb_bus.wb_ack}, 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      d_rst      = ($urandom_range(0, 299) == 0);
      d_cyc      = ($urandom_range(0, 9) < 8);
      d_stb      = ($urandom_range(0, 9) < 6);
      d_we       = 1'($urandom_range(0, 1));
      d_adr      = 2'($urandom_range(0, 3));
      d_dat      = 8'($urandom_range(0, 255));
      if (d_we && d_adr == 2'd2 && $urandom_range(0, 3) != 0) d_adr = 2'd0;
      d_tx_ready = ($urandom_range(0, 2) == 0);
      d_rx_valid = 1'($urandom_range(0, 1));
      d_rx_data  = 8'($urandom_range(0, 255));
      tick();
    end
    d_rst = 0; d_cyc = 0; d_stb = 0; d_rx_valid = 0; d_tx_ready = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
